// File: rtl/mcs8_pkg.sv
// Shared constants for the MCS-8 fetch front end: T-state codes, cycle types and HLT opcodes.
package mcs8_pkg;

  // Enumerator values are the external T-state codes driven on STATE_O.
  typedef enum logic [2:0] {
    StWait    = 3'b000,
    StT3      = 3'b001,
    StT1      = 3'b010,
    StStopped = 3'b011,
    StT2      = 3'b100,
    StT5      = 3'b101,
    StT1i     = 3'b110,
    StT4      = 3'b111
  } tstate_e;

  localparam logic [1:0] CycPci = 2'b00;
  localparam logic [1:0] CycPcr = 2'b10;
  localparam logic [1:0] CycPcc = 2'b01;
  localparam logic [1:0] CycPcw = 2'b11;

  localparam logic [7:0] OpHlt0  = 8'h00;
  localparam logic [7:0] OpHlt1  = 8'h01;
  localparam logic [7:0] OpHltFf = 8'hFF;

  function automatic logic is_hlt(logic [7:0] op);
    return (op == OpHlt0) || (op == OpHlt1) || (op == OpHltFf);
  endfunction

endpackage

// File: rtl/mcs8_phase_gen.sv
// Eight-phase counter per T-state; registered two-phase bus clocks, SYNC and end-of-state strobe.
module mcs8_phase_gen (
  input  logic clk,
  input  logic rst_n,
  output logic clk1,
  output logic clk2,
  output logic sync,
  output logic eos
);

  logic [2:0] ph_q;
  logic [2:0] ph_d;

  assign ph_d = ph_q + 3'd1;
  assign eos  = (ph_q == 3'd7);

  // Bus clocks are registered from the upcoming phase so they line up with ph_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 3'd0;
      clk1 <= 1'b0;
      clk2 <= 1'b0;
      sync <= 1'b1;
    end else begin
      ph_q <= ph_d;
      clk1 <= (ph_d == 3'd0) || (ph_d == 3'd4);
      clk2 <= (ph_d == 3'd2) || (ph_d == 3'd6);
      sync <= (ph_d < 3'd4);
    end
  end

endmodule

// File: rtl/mcs8_fetch_sequencer.sv
// MCS-8 instruction-fetch sequencer: T-state machine, PC, IR and multiplexed bus byte.
// Optional debug outputs PC_O/IR_O/HALT_O are enabled by defining MCS8_DEBUG_PORT_EN.
module mcs8_fetch_sequencer
  import mcs8_pkg::*;
#(
  parameter logic [13:0] RESET_PC = 14'h0000
) (
  input  logic       CLK_I,
  input  logic       nRST_I,
  output logic       CLK1_O,
  output logic       CLK2_O,
  output logic       SYNC_O,
  output logic [2:0] STATE_O,
  input  logic       READY_I,
  input  logic       INT_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O
`ifdef MCS8_DEBUG_PORT_EN
  ,
  output logic [13:0] PC_O,
  output logic [7:0]  IR_O,
  output logic        HALT_O
`endif
);

  logic eos;

  tstate_e     state_q, state_d;
  logic [13:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  dat_q, dat_d;
  logic        int_cyc_q, int_cyc_d;

  mcs8_phase_gen u_phase_gen (
    .clk   (CLK_I),
    .rst_n (nRST_I),
    .clk1  (CLK1_O),
    .clk2  (CLK2_O),
    .sync  (SYNC_O),
    .eos   (eos)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    int_cyc_d = int_cyc_q;
    if (eos) begin
      unique case (state_q)
        StT1, StT1i: state_d = StT2;
        StT2:        state_d = READY_I ? StT3 : StWait;
        StWait:      state_d = READY_I ? StT3 : StWait;
        StT3: begin
          ir_d = DAT_I;
          // Interrupt-acknowledge fetches leave the PC alone.
          if (!int_cyc_q) pc_d = pc_q + 14'd1;
          state_d = is_hlt(DAT_I) ? StStopped : StT4;
        end
        StT4:        state_d = StT5;
        StT5, StStopped: begin
          if (INT_I) begin
            state_d   = StT1i;
            int_cyc_d = 1'b1;
          end else if (state_q == StT5) begin
            state_d   = StT1;
            int_cyc_d = 1'b0;
          end
        end
        default:     state_d = StT1;
      endcase
    end
  end

  always_comb begin
    dat_d = 8'h00;
    unique case (state_d)
      StT1, StT1i: dat_d = pc_d[7:0];
      StT2:        dat_d = {CycPci, pc_d[13:8]};
      default:     dat_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state_q   <= StT1;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      int_cyc_q <= 1'b0;
      dat_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      int_cyc_q <= int_cyc_d;
      dat_q     <= dat_d;
    end
  end

  assign STATE_O = state_q;
  assign DAT_O   = dat_q;

`ifdef MCS8_DEBUG_PORT_EN
  logic halt_q;

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) halt_q <= 1'b0;
    else         halt_q <= (state_d == StStopped);
  end

  assign PC_O   = pc_q;
  assign IR_O   = ir_q;
  assign HALT_O = halt_q;
`else
  logic unused_ir;
  assign unused_ir = ^ir_q;
`endif

endmodule

// File: tb/tb_mcs8_fetch_sequencer.sv
// Randomized bench for mcs8_fetch_sequencer against a T-state-level reference model.
module tb_mcs8_fetch_sequencer;

  localparam logic [13:0] TbResetPc = 14'h3FFF;

  localparam logic [2:0] ST_T1 = 3'b010, ST_T2 = 3'b100, ST_T3 = 3'b001, ST_T4 = 3'b111;
  localparam logic [2:0] ST_T5 = 3'b101, ST_WAIT = 3'b000, ST_T1I = 3'b110, ST_STOP = 3'b011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk1, clk2, sync;
  logic [2:0] state;
  logic       ready, intr;
  logic [7:0] dat_in, dat_out;
`ifdef MCS8_DEBUG_PORT_EN
  logic [13:0] pc_dbg;
  logic [7:0]  ir_dbg;
  logic        halt_dbg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, one step per T-state.
  logic [2:0]  m_state;
  logic [13:0] m_pc;
  logic [7:0]  m_ir;
  bit          m_int_cyc;
  bit          m_fresh;

  always #5 clk = ~clk;

  mcs8_fetch_sequencer #(
    .RESET_PC (TbResetPc)
  ) dut (
    .CLK_I   (clk),
    .nRST_I  (rst_n),
    .CLK1_O  (clk1),
    .CLK2_O  (clk2),
    .SYNC_O  (sync),
    .STATE_O (state),
    .READY_I (ready),
    .INT_I   (intr),
    .DAT_I   (dat_in),
    .DAT_O   (dat_out)
`ifdef MCS8_DEBUG_PORT_EN
    ,
    .PC_O    (pc_dbg),
    .IR_O    (ir_dbg),
    .HALT_O  (halt_dbg)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_dat(input logic [2:0] st, input logic [13:0] pc);
    if (st == ST_T1 || st == ST_T1I) return pc[7:0];
    if (st == ST_T2) return {2'b00, pc[13:8]};
    return 8'h00;
  endfunction

  function automatic bit is_halt_op(input logic [7:0] op);
    return op == 8'h00 || op == 8'h01 || op == 8'hFF;
  endfunction

  task automatic model_reset();
    m_state   = ST_T1;
    m_pc      = TbResetPc;
    m_ir      = 8'h00;
    m_int_cyc = 1'b0;
    m_fresh   = 1'b1;
  endtask

  task automatic model_step(input bit rdy, input bit irq, input logic [7:0] op);
    case (m_state)
      ST_T1, ST_T1I: begin
        m_int_cyc = (m_state == ST_T1I);
        m_state   = ST_T2;
      end
      ST_T2, ST_WAIT: m_state = rdy ? ST_T3 : ST_WAIT;
      ST_T3: begin
        m_ir = op;
        if (!m_int_cyc) m_pc = 14'((int'(m_pc) + 1) % 16384);
        m_state = is_halt_op(op) ? ST_STOP : ST_T4;
      end
      ST_T4:   m_state = ST_T5;
      ST_T5:   m_state = irq ? ST_T1I : ST_T1;
      ST_STOP: m_state = irq ? ST_T1I : ST_STOP;
      default: m_state = ST_T1;
    endcase
  endtask

  // Starts at a falling edge with the DUT at phase 0; ends at phase 0 of the next T-state.
  task automatic do_state(input bit rdy, input bit irq, input logic [7:0] op, input bit glitch);
    ready  = rdy;
    dat_in = op;
    intr   = glitch ? 1'b0 : irq;
    for (int p = 0; p < 8; p++) begin
      check("state", 32'(state), 32'(m_state));
      check("clk1", 32'(clk1), 32'((p == 0 || p == 4) && !(p == 0 && m_fresh)));
      check("clk2", 32'(clk2), 32'(p == 2 || p == 6));
      check("sync", 32'(sync), 32'(p < 4));
      check("clk_overlap", 32'(clk1 & clk2), 32'(0));
      if (p != 0 || !m_fresh) check("dat_out", 32'(dat_out), 32'(exp_dat(m_state, m_pc)));
`ifdef MCS8_DEBUG_PORT_EN
      check("pc_dbg", 32'(pc_dbg), 32'(m_pc));
      check("ir_dbg", 32'(ir_dbg), 32'(m_ir));
      if (p != 0 || !m_fresh) check("halt_dbg", 32'(halt_dbg), 32'(m_state == ST_STOP));
`endif
      if (glitch && p == 2) intr = 1'b1;
      if (glitch && p == 5) intr = irq;
      @(negedge clk);
    end
    model_step(rdy, irq, op);
    m_fresh = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'(ST_T1));
    check({tag, "_dat"}, 32'(dat_out), 32'h00);
    check({tag, "_sync"}, 32'(sync), 32'(1));
    check({tag, "_clk1"}, 32'(clk1), 32'(0));
    check({tag, "_clk2"}, 32'(clk2), 32'(0));
  endtask

  initial begin
    logic [7:0] op;
    int guard;
    rst_n  = 1'b0;
    ready  = 1'b1;
    intr   = 1'b0;
    dat_in = 8'hC0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    model_reset();

    // Two plain fetches: PC wraps from 3FFF to 0000.
    repeat (10) do_state(1'b1, 1'b0, 8'hC0, 1'b0);

    // Three WAIT states, then opcode 55 continues to T4.
    do_state(1'b1, 1'b0, 8'h55, 1'b0);
    repeat (3) do_state(1'b0, 1'b0, 8'h55, 1'b0);
    repeat (4) do_state(1'b1, 1'b0, 8'h55, 1'b0);

    // HLT opcode, ignored interrupt glitches, then interrupt entry.
    repeat (3) do_state(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) do_state(1'b1, 1'b0, 8'h00, 1'b1);
    do_state(1'b1, 1'b1, 8'h00, 1'b0);
    repeat (10) do_state(1'b1, 1'b0, 8'hC0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      op = 8'($urandom);
      if ($urandom_range(0, 5) == 0) op = ($urandom_range(0, 2) == 0) ? 8'h01 : 8'hFF;
      do_state($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, op, $urandom_range(0, 2) == 0);
    end

    // Steer into WAIT, then reset asynchronously mid-state.
    guard = 0;
    while (m_state != ST_T2 && guard < 20) begin
      do_state(1'b1, 1'b1, 8'hC0, 1'b0);
      guard++;
    end
    check("reach_t2", 32'(m_state), 32'(ST_T2));
    do_state(1'b0, 1'b0, 8'hC0, 1'b0);
    check("state_wait", 32'(state), 32'(ST_WAIT));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    check_reset_values("held_rst");
    rst_n = 1'b1;
    model_reset();
    repeat (10) do_state(1'b1, 1'b0, 8'hC0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
